// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-side bus bridge: IO address map and the
// seven-segment hex decoder used by the display scanner.
package bridge_pkg;

  localparam logic [19:0] IO_BASE_HI = 20'hFFFFF;

  // Offsets within the 4 KiB IO page, word-aligned.
  localparam logic [11:0] ADDR_DIG  = 12'h000;
  localparam logic [11:0] ADDR_TCNT = 12'h020;
  localparam logic [11:0] ADDR_TDIV = 12'h024;
  localparam logic [11:0] ADDR_LED  = 12'h060;
  localparam logic [11:0] ADDR_SW   = 12'h070;
  localparam logic [11:0] ADDR_BTN  = 12'h078;

  // Active-low segments {DP,G,F,E,D,C,B,A}; DP always off.
  function automatic logic [7:0] seg7_hex(input logic [3:0] value);
    logic [7:0] pattern;
    pattern = 8'hFF;
    case (value)
      4'h0: pattern = 8'hC0;
      4'h1: pattern = 8'hF9;
      4'h2: pattern = 8'hA4;
      4'h3: pattern = 8'hB0;
      4'h4: pattern = 8'h99;
      4'h5: pattern = 8'h92;
      4'h6: pattern = 8'h82;
      4'h7: pattern = 8'hF8;
      4'h8: pattern = 8'h80;
      4'h9: pattern = 8'h90;
      4'hA: pattern = 8'h88;
      4'hB: pattern = 8'h83;
      4'hC: pattern = 8'hC6;
      4'hD: pattern = 8'hA1;
      4'hE: pattern = 8'h86;
      4'hF: pattern = 8'h8E;
      default: pattern = 8'hFF;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bus_bridge_io_seg7_scan.sv
// Multiplexed 8-digit seven-segment scanner: each digit is driven for
// SCAN_DIV cycles; outputs are registered from the current digit index.
module seg7_scan
  import bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic          scan_wrap;

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; idx below is read before it advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      dig_en   <= 8'hFF;
      dig_seg  <= 8'hFF;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) idx <= idx + 3'd1;
      dig_en  <= ~(8'b1 << idx);
      dig_seg <= seg7_hex(dig[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/bus_bridge_io.sv
// CPU data-bus responder: forwards non-IO accesses to DRAM and serves the
// memory-mapped LED, switch, button, display and timer registers.
module bus_bridge_io
  import bridge_pkg::*;
#(
  parameter int DRAM_AW   = 14,
  parameter int SCAN_DIV  = 20000,
  parameter int TIMER_DIV = 1
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  output logic [23:0]        led,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic        is_io;
  logic [11:0] io_off;
  logic        io_wr;
  logic [31:0] io_rdata;

  logic [31:0] dig_reg;
  logic [31:0] tcnt;
  logic [31:0] tdiv;
  logic [31:0] tdiv_eff;
  logic [31:0] presc;
  logic        tick;
  logic        tcnt_wr;
  logic        tdiv_wr;

  logic [23:0] sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;

  // Byte-lane bits are masked off: only word accesses exist.
  assign is_io  = (Bus_addr[31:12] == IO_BASE_HI);
  assign io_off = Bus_addr[11:0] & 12'hFFC;
  assign io_wr  = Bus_wen & is_io;

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~is_io & cpu_rst;

  assign tcnt_wr  = io_wr && (io_off == ADDR_TCNT);
  assign tdiv_wr  = io_wr && (io_off == ADDR_TDIV);
  assign tdiv_eff = (tdiv == '0) ? 32'd1 : tdiv;
  assign tick     = (presc == tdiv_eff - 32'd1);

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      led     <= '0;
      dig_reg <= '0;
    end else begin
      if (io_wr && io_off == ADDR_LED) led     <= Bus_wdata[23:0];
      if (io_wr && io_off == ADDR_DIG) dig_reg <= Bus_wdata;
    end
  end

  // A CPU write to TCNT wins over a prescaler tick in the same cycle.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      tcnt  <= '0;
      tdiv  <= 32'(TIMER_DIV);
      presc <= '0;
    end else begin
      if (tdiv_wr) tdiv <= Bus_wdata;
      if (tcnt_wr)   tcnt <= Bus_wdata;
      else if (tick) tcnt <= tcnt + 32'd1;
      if (tcnt_wr || tdiv_wr || tick) presc <= '0;
      else                            presc <= presc + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // NOTE: io_rdata gets a default before the case so no latch is inferred
  // for unmapped offsets.
  always_comb begin
    io_rdata = '0;
    case (io_off)
      ADDR_DIG:  io_rdata = dig_reg;
      ADDR_TCNT: io_rdata = tcnt;
      ADDR_TDIV: io_rdata = tdiv;
      ADDR_LED:  io_rdata = {8'h00, led};
      ADDR_SW:   io_rdata = {8'h00, sw_s2};
      ADDR_BTN:  io_rdata = {27'h0, btn_s2};
      default:   io_rdata = '0;
    endcase
  end

  assign Bus_rdata = is_io ? io_rdata : dram_rdata;

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk    (cpu_clk),
    .rst_n  (cpu_rst),
    .dig    (dig_reg),
    .dig_en (dig_en),
    .dig_seg(dig_seg)
  );

endmodule

// File: tb/tb_bus_bridge_io.sv
// Directed bench for bus_bridge_io: table of single-cycle bus accesses plus
// hand-written sequences for synchronisers, timer, display scan and reset.
module tb_bus_bridge_io;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] led;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int checks   = 0;
  int failures = 0;

  bus_bridge_io #(
    .DRAM_AW  (14),
    .SCAN_DIV (4),
    .TIMER_DIV(1)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .Bus_addr  (Bus_addr),
    .Bus_wen   (Bus_wen),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata),
    .dram_addr (dram_addr),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .led       (led),
    .sw        (sw),
    .btn       (btn),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_wen;
    logic [13:0] exp_daddr;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Bus_addr  = addr;
    Bus_wdata = data;
    Bus_wen   = 1'b1;
    step();
    Bus_wen = 1'b0;
    #1;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    Bus_addr = addr;
    #1;
    check(name, Bus_rdata, exp);
  endtask

  task automatic scan_check(input string name, input logic [7:0] en, input logic [7:0] seg);
    check({name, "_en"},  {24'h0, dig_en},  {24'h0, en});
    check({name, "_seg"}, {24'h0, dig_seg}, {24'h0, seg});
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 14'h0004, 24'h000000};
    vecs[1] = '{32'hFFFF_F060, 1'b1, 32'hFFA5_A5A5, 32'h0000_0000, 1'b0, 14'h3C18, 24'hA5A5A5};
    vecs[2] = '{32'hFFFF_F060, 1'b0, 32'h0000_0000, 32'h00A5_A5A5, 1'b0, 14'h3C18, 24'hA5A5A5};
    vecs[3] = '{32'hFFFF_F100, 1'b1, 32'h0000_0055, 32'h0000_0000, 1'b0, 14'h3C40, 24'hA5A5A5};
    vecs[4] = '{32'hFFFF_F004, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 14'h3C01, 24'hA5A5A5};
    vecs[5] = '{32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 14'h3C1C, 24'hA5A5A5};
    vecs[6] = '{32'h0000_0FFC, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0, 14'h03FF, 24'hA5A5A5};
    vecs[7] = '{32'hFFFF_E060, 1'b1, 32'h0000_0011, 32'h1234_5678, 1'b1, 14'h3818, 24'hA5A5A5};
    vecs[8] = '{32'hFFFF_F000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 14'h3C00, 24'hA5A5A5};

    cpu_rst    = 1'b0;
    Bus_addr   = '0;
    Bus_wen    = 1'b0;
    Bus_wdata  = '0;
    dram_rdata = 32'h1234_5678;
    sw         = '0;
    btn        = '0;

    // Reset state
    step();
    step();
    Bus_addr = 32'h0000_0020;
    Bus_wen  = 1'b1;
    #1;
    check("rst_dram_wen", {31'h0, dram_wen}, 32'h0);
    check("rst_led", {8'h0, led}, 32'h0);
    scan_check("rst_scan", 8'hFF, 8'hFF);
    Bus_wen = 1'b0;
    cpu_rst = 1'b1;
    step();
    scan_check("first_scan", 8'hFE, 8'hC0);

    // Single-access table
    for (int i = 0; i < 9; i++) begin
      Bus_addr  = vecs[i].addr;
      Bus_wen   = vecs[i].wen;
      Bus_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), Bus_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_dram_wen", i), {31'h0, dram_wen}, {31'h0, vecs[i].exp_wen});
      check($sformatf("vec%0d_dram_addr", i), {18'h0, dram_addr}, {18'h0, vecs[i].exp_daddr});
      if (vecs[i].wen)
        check($sformatf("vec%0d_dram_wdata", i), dram_wdata, vecs[i].wdata);
      step();
      Bus_wen = 1'b0;
      check($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
    end

    // Switch / button synchronisers: visible after exactly two edges
    sw = 24'h123456;
    read_check("sw_edge0", 32'hFFFF_F070, 32'h0);
    step();
    read_check("sw_edge1", 32'hFFFF_F070, 32'h0);
    step();
    read_check("sw_edge2", 32'hFFFF_F070, 32'h0012_3456);
    btn = 5'h1F;
    read_check("btn_edge0", 32'hFFFF_F078, 32'h0);
    step();
    read_check("btn_edge1", 32'hFFFF_F078, 32'h0);
    step();
    read_check("btn_edge2", 32'hFFFF_F078, 32'h0000_001F);

    // Timer with TDIV=1, wrap through FFFF_FFFF
    read_check("tdiv_reset", 32'hFFFF_F024, 32'h1);
    bus_write(32'hFFFF_F020, 32'hFFFF_FFFE);
    read_check("tcnt_load", 32'hFFFF_F020, 32'hFFFF_FFFE);
    step();
    read_check("tcnt_max", 32'hFFFF_F020, 32'hFFFF_FFFF);
    step();
    read_check("tcnt_wrap", 32'hFFFF_F020, 32'h0);

    // TDIV=3: one increment every three cycles
    bus_write(32'hFFFF_F024, 32'd3);
    read_check("tdiv_rd", 32'hFFFF_F024, 32'd3);
    bus_write(32'hFFFF_F020, 32'd100);
    read_check("div3_w0", 32'hFFFF_F020, 32'd100);
    step();
    read_check("div3_w1", 32'hFFFF_F020, 32'd100);
    step();
    read_check("div3_w2", 32'hFFFF_F020, 32'd100);
    step();
    read_check("div3_w3", 32'hFFFF_F020, 32'd101);
    step();
    step();
    read_check("div3_w5", 32'hFFFF_F020, 32'd101);
    // The next edge is a tick edge; the write must win
    bus_write(32'hFFFF_F020, 32'd500);
    read_check("tick_wr0", 32'hFFFF_F020, 32'd500);
    step();
    step();
    read_check("tick_wr2", 32'hFFFF_F020, 32'd500);
    step();
    read_check("tick_wr3", 32'hFFFF_F020, 32'd501);

    // TDIV=0 behaves as 1
    bus_write(32'hFFFF_F024, 32'd0);
    bus_write(32'hFFFF_F020, 32'd7);
    read_check("div0_w0", 32'hFFFF_F020, 32'd7);
    step();
    read_check("div0_w1", 32'hFFFF_F020, 32'd8);

    // Display scan from a known phase: reset, then write DIG on the first edge
    cpu_rst = 1'b0;
    step();
    cpu_rst   = 1'b1;
    Bus_addr  = 32'hFFFF_F000;
    Bus_wdata = 32'h0000_00F8;
    Bus_wen   = 1'b1;
    step();
    Bus_wen = 1'b0;
    scan_check("scan_e1", 8'hFE, 8'hC0);
    read_check("dig_rd", 32'hFFFF_F000, 32'h0000_00F8);
    step();
    scan_check("scan_e2", 8'hFE, 8'h80);
    step();
    step();
    scan_check("scan_e4", 8'hFE, 8'h80);
    step();
    scan_check("scan_e5", 8'hFD, 8'h8E);
    for (int i = 0; i < 3; i++) step();
    scan_check("scan_e8", 8'hFD, 8'h8E);
    step();
    scan_check("scan_e9", 8'hFB, 8'hC0);
    for (int i = 0; i < 20; i++) step();
    scan_check("scan_e29", 8'h7F, 8'hC0);
    for (int i = 0; i < 4; i++) step();
    scan_check("scan_e33", 8'hFE, 8'h80);

    // Mid-run reset with state nonzero and a DRAM write pending
    bus_write(32'hFFFF_F060, 32'h00C3_C3C3);
    check("pre_rst_led", {8'h0, led}, 32'h00C3_C3C3);
    cpu_rst   = 1'b0;
    Bus_addr  = 32'h0000_0020;
    Bus_wdata = 32'h0000_0001;
    Bus_wen   = 1'b1;
    #1;
    check("midrst_dram_wen", {31'h0, dram_wen}, 32'h0);
    step();
    Bus_wen = 1'b0;
    check("midrst_led", {8'h0, led}, 32'h0);
    scan_check("midrst_scan", 8'hFF, 8'hFF);
    read_check("midrst_tcnt", 32'hFFFF_F020, 32'h0);
    read_check("midrst_tdiv", 32'hFFFF_F024, 32'h1);
    read_check("midrst_dig", 32'hFFFF_F000, 32'h0);
    read_check("midrst_sw", 32'hFFFF_F070, 32'h0);
    step();
    read_check("midrst_hold_tcnt", 32'hFFFF_F020, 32'h0);
    scan_check("midrst_hold_scan", 8'hFF, 8'hFF);
    cpu_rst = 1'b1;
    step();
    scan_check("release_scan", 8'hFE, 8'hC0);
    read_check("release_sw", 32'hFFFF_F070, 32'h0);
    read_check("release_tcnt", 32'hFFFF_F020, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
